// File: rtl/status_flag_arbiter_pkg.sv
// Shared types and constants for the status-flag arbiter: FSM state encoding,
// flag bit positions and the default flag-bank width.
package status_flag_pkg;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    GNT    = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  localparam int DEFAULT_N_FLAGS = 4;

endpackage

// File: rtl/status_flag_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or above
// i_ptr, wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_onehot,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_valid
);

  // Walk the requesters starting from the pointer; the first hit wins.
  always_comb begin
    o_onehot = {N_REQ{1'b0}};
    o_idx    = {PTR_W{1'b0}};
    o_valid  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!o_valid && i_req[(int'(i_ptr) + k) % N_REQ]) begin
        o_valid  = 1'b1;
        o_idx    = PTR_W'((int'(i_ptr) + k) % N_REQ);
        o_onehot[(int'(i_ptr) + k) % N_REQ] = 1'b1;
      end else begin
        o_valid  = o_valid;
      end
    end
  end

endmodule

// File: rtl/status_flag_arbiter.sv
// CPU status-flag bank with round-robin write arbitration and optional lock.
// Optional macro STATUS_FLAG_ARBITER_BYPASS_EN forwards a pending commit to READ_FLAGS.
module status_flag_arbiter
  import status_flag_pkg::*;
#(
  parameter int                 N_REQ    = 3,
  parameter int                 N_FLAGS  = DEFAULT_N_FLAGS,
  parameter logic [N_FLAGS-1:0] INIT     = {N_FLAGS{1'b0}},
  parameter int                 LOCK_MAX = 15
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [N_REQ-1:0]           REQ,
  input  logic [N_REQ-1:0]           LOCK,
  input  logic [N_REQ*N_FLAGS-1:0]   FLAG_MASK,
  input  logic [N_REQ*N_FLAGS-1:0]   FLAG_DATA,
  output logic [N_REQ-1:0]           GRANT,
  output logic [N_FLAGS-1:0]         READ_FLAGS,
  output logic                       TIMEOUT
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_t         r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_win;
  logic [N_REQ-1:0]   r_grant;
  logic [N_FLAGS-1:0] r_flags;
  logic               r_timeout;
  logic [CNT_W-1:0]   r_lock_cnt;

  logic [N_REQ-1:0]   w_pick_onehot;
  logic [PTR_W-1:0]   w_pick_idx;
  logic               w_pick_valid;
  logic               w_req_w;
  logic               w_lock_w;
  logic [N_FLAGS-1:0] w_mask;
  logic [N_FLAGS-1:0] w_data;
  logic [N_FLAGS-1:0] w_merged;
  logic               w_commit;
  logic [PTR_W-1:0]   w_next_ptr;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .i_req    (REQ),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  assign w_req_w    = REQ[r_win];
  assign w_lock_w   = LOCK[r_win];
  assign w_mask     = FLAG_MASK[int'(r_win)*N_FLAGS +: N_FLAGS];
  assign w_data     = FLAG_DATA[int'(r_win)*N_FLAGS +: N_FLAGS];
  assign w_merged   = (r_flags & ~w_mask) | (w_data & w_mask);
  assign w_commit   = (r_state != ARB) && w_req_w;
  assign w_next_ptr = (r_win == PTR_W'(N_REQ - 1)) ? {PTR_W{1'b0}} : r_win + PTR_W'(1);

  // Arbitration FSM and flag bank; all state advances on the falling edge.
  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= ARB;
      r_ptr      <= {PTR_W{1'b0}};
      r_win      <= {PTR_W{1'b0}};
      r_grant    <= {N_REQ{1'b0}};
      r_flags    <= INIT;
      r_timeout  <= 1'b0;
      r_lock_cnt <= {CNT_W{1'b0}};
    end else begin
      if (w_commit) begin
        r_flags <= w_merged;
      end
      case (r_state)
        ARB: begin
          if (w_pick_valid) begin
            r_win   <= w_pick_idx;
            r_grant <= w_pick_onehot;
            r_state <= GNT;
          end else begin
            r_grant <= {N_REQ{1'b0}};
          end
        end
        GNT: begin
          if (!w_req_w) begin
            r_grant <= {N_REQ{1'b0}};
            r_state <= ARB;
          end else if (!w_lock_w) begin
            r_grant <= {N_REQ{1'b0}};
            r_ptr   <= w_next_ptr;
            r_state <= ARB;
          end else begin
            r_lock_cnt <= CNT_W'(1);
            r_state    <= LOCKED;
          end
        end
        LOCKED: begin
          if (!w_req_w || !w_lock_w) begin
            r_grant <= {N_REQ{1'b0}};
            r_ptr   <= w_next_ptr;
            r_state <= ARB;
          end else if (r_lock_cnt == CNT_W'(LOCK_MAX)) begin
            r_timeout <= 1'b1;
            r_grant   <= {N_REQ{1'b0}};
            r_ptr     <= w_next_ptr;
            r_state   <= ARB;
          end else begin
            r_lock_cnt <= r_lock_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_grant <= {N_REQ{1'b0}};
          r_state <= ARB;
        end
      endcase
    end
  end

  assign GRANT   = r_grant;
  assign TIMEOUT = r_timeout;

`ifdef STATUS_FLAG_ARBITER_BYPASS_EN
  assign READ_FLAGS = w_commit ? w_merged : r_flags;
`else
  assign READ_FLAGS = r_flags;
`endif

endmodule
